spectrum_bar_driver: RTL and testbench

//  Sits directly downstream of the FFT/magnitude stage. It converts each completed frame of bin

---
 rtl/spectrum_bar_driver.sv | 212 +++++++++++++++++++++
 tb/tb_spectrum_bar_driver.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_bar_driver.sv
// spectrum_bar_driver
//   Turns each completed frame of FFT bin magnitudes into quantised LED bar
//   heights. Each bar falls by at most DECAY levels per frame and carries a
//   peak-hold marker. Bars are then streamed one per valid/ready handshake.
//
// Ports
//   clk         : single clock
//   reset_n     : asynchronous assert, synchronous release, active low
//   magnitudes  : MAG_W x SAMPLES bin magnitudes; only bins 0..BARS-1 are used
//   frame_done  : upstream done level; its rising edge starts a frame
//   bar_ready   : downstream accepts the presented bar this cycle
//   bar_valid   : bar_index/bar_level/peak_level/bar_last are valid
//   bar_index   : bar number 0..BARS-1
//   bar_level   : smoothed bar height
//   peak_level  : peak-hold marker height
//   bar_last    : marks the beat carrying bar BARS-1
//   busy        : high whenever a frame is being updated or sent
//   drop_count  : frames ignored because one was in flight, saturates at 255
module spectrum_bar_driver #(
  parameter int SAMPLES     = 16,
  parameter int MAG_W       = 18,
  parameter int BARS        = 8,
  parameter int LEVEL_W     = 4,
  parameter int SHIFT       = 8,
  parameter int DECAY       = 1,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [MAG_W-1:0]        magnitudes [SAMPLES],
  input  logic                    frame_done,
  input  logic                    bar_ready,
  output logic                    bar_valid,
  output logic [$clog2(BARS)-1:0] bar_index,
  output logic [LEVEL_W-1:0]      bar_level,
  output logic [LEVEL_W-1:0]      peak_level,
  output logic                    bar_last,
  output logic                    busy,
  output logic [7:0]              drop_count
);

  localparam int IDX_W  = $clog2(BARS);
  // k runs one step past the last bar so the first beat lands BARS+1 edges
  // after the capture edge.
  localparam int K_W    = $clog2(BARS + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [K_W-1:0]     K_DONE    = K_W'(BARS);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(BARS - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = {LEVEL_W{1'b1}};
  localparam logic [MAG_W-1:0]   LVL_MAX_W = MAG_W'((1 << LEVEL_W) - 1);
  localparam logic [LEVEL_W-1:0] DECAY_L   = LEVEL_W'(DECAY);
  localparam logic [HOLD_W-1:0]  HOLD_L    = HOLD_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, UPDATE, SEND} state_t;

  state_t             state_q;
  logic               frame_done_q;
  logic [K_W-1:0]     k_q;
  logic [MAG_W-1:0]   snap_q [BARS];
  logic [LEVEL_W-1:0] bar_q  [BARS];
  logic [LEVEL_W-1:0] peak_q [BARS];
  logic [HOLD_W-1:0]  hold_q [BARS];

  logic               bar_valid_q;
  logic [IDX_W-1:0]   bar_index_q;
  logic [LEVEL_W-1:0] bar_level_q;
  logic [LEVEL_W-1:0] peak_level_q;
  logic               bar_last_q;
  logic               busy_q;
  logic [7:0]         drop_count_q;

  logic fe;
  assign fe = frame_done & ~frame_done_q;

  // Upper bins are the mirror image of the lower ones for real input and
  // carry no extra information; fold them so they are visibly accounted for.
  logic [MAG_W-1:0] unused_upper_bins;
  always_comb begin
    unused_upper_bins = '0;
    for (int i = BARS; i < SAMPLES; i++) unused_upper_bins ^= magnitudes[i];
  end

  // Quantise every snapshot bin: shift at full width, then saturate.
  logic [LEVEL_W-1:0] lvl_all [BARS];
  generate
    for (genvar gi = 0; gi < BARS; gi++) begin : g_quant
      logic [MAG_W-1:0] shifted;
      assign shifted     = snap_q[gi] >> SHIFT;
      assign lvl_all[gi] = (shifted > LVL_MAX_W) ? LVL_MAX : shifted[LEVEL_W-1:0];
    end
  endgenerate

  // Smoothing and peak-hold for the bar currently addressed by k.
  logic [IDX_W-1:0]   k_idx;
  logic [LEVEL_W-1:0] lvl_k, bar_old, peak_old, bar_dec, peak_dec;
  logic [HOLD_W-1:0]  hold_old;
  logic [LEVEL_W-1:0] bar_d, peak_d;
  logic [HOLD_W-1:0]  hold_d;

  assign k_idx    = k_q[IDX_W-1:0];
  assign lvl_k    = lvl_all[k_idx];
  assign bar_old  = bar_q[k_idx];
  assign peak_old = peak_q[k_idx];
  assign hold_old = hold_q[k_idx];

  always_comb begin
    bar_dec  = (bar_old > DECAY_L) ? (bar_old - DECAY_L) : '0;
    peak_dec = (peak_old != '0) ? (peak_old - LEVEL_W'(1)) : '0;
    if (lvl_k >= bar_old) bar_d = lvl_k;
    else                  bar_d = (lvl_k > bar_dec) ? lvl_k : bar_dec;

    peak_d = peak_old;
    hold_d = hold_old;
    if (bar_d >= peak_old) begin
      peak_d = bar_d;
      hold_d = HOLD_L;
    end else if (hold_old != '0) begin
      hold_d = hold_old - HOLD_W'(1);
    end else begin
      peak_d = (bar_d > peak_dec) ? bar_d : peak_dec;
    end
  end

  logic [IDX_W-1:0] idx_next;
  assign idx_next = bar_index_q + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
      k_q          <= '0;
      for (int i = 0; i < BARS; i++) begin
        snap_q[i] <= '0;
        bar_q[i]  <= '0;
        peak_q[i] <= '0;
        hold_q[i] <= '0;
      end
      bar_valid_q  <= 1'b0;
      bar_index_q  <= '0;
      bar_level_q  <= '0;
      peak_level_q <= '0;
      bar_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      frame_done_q <= frame_done;

      // Any new frame edge outside IDLE is dropped, including the cycle of
      // the final handshake (state is still SEND then).
      if (fe && (state_q != IDLE) && (drop_count_q != 8'hFF))
        drop_count_q <= drop_count_q + 8'd1;

      case (state_q)
        IDLE: begin
          if (fe) begin
            for (int i = 0; i < BARS; i++) snap_q[i] <= magnitudes[i];
            k_q     <= '0;
            state_q <= UPDATE;
            busy_q  <= 1'b1;
          end
        end

        UPDATE: begin
          if (k_q == K_DONE) begin
            state_q      <= SEND;
            bar_valid_q  <= 1'b1;
            bar_index_q  <= '0;
            bar_level_q  <= bar_q[0];
            peak_level_q <= peak_q[0];
            bar_last_q   <= (BARS == 1);
          end else begin
            bar_q[k_idx]  <= bar_d;
            peak_q[k_idx] <= peak_d;
            hold_q[k_idx] <= hold_d;
            k_q           <= k_q + K_W'(1);
          end
        end

        SEND: begin
          if (bar_ready) begin
            if (bar_last_q) begin
              state_q      <= IDLE;
              bar_valid_q  <= 1'b0;
              bar_index_q  <= '0;
              bar_level_q  <= '0;
              peak_level_q <= '0;
              bar_last_q   <= 1'b0;
              busy_q       <= 1'b0;
            end else begin
              bar_index_q  <= idx_next;
              bar_level_q  <= bar_q[idx_next];
              peak_level_q <= peak_q[idx_next];
              bar_last_q   <= (idx_next == IDX_LAST);
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bar_valid  = bar_valid_q;
  assign bar_index  = bar_index_q;
  assign bar_level  = bar_level_q;
  assign peak_level = peak_level_q;
  assign bar_last   = bar_last_q;
  assign busy       = busy_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_spectrum_bar_driver.sv
module tb_spectrum_bar_driver;

  localparam int SAMPLES = 16;
  localparam int MAG_W   = 18;
  localparam int BARS    = 8;
  localparam int LEVEL_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [MAG_W-1:0] mags [SAMPLES];
  logic             frame_done = 1'b0;
  logic             bar_ready = 1'b0;
  logic             bar_valid;
  logic [2:0]       bar_index;
  logic [3:0]       bar_level;
  logic [3:0]       peak_level;
  logic             bar_last;
  logic             busy;
  logic [7:0]       drop_count;

  int checks   = 0;
  int failures = 0;

  logic [2:0] got_idx  [BARS];
  logic [3:0] got_bar  [BARS];
  logic [3:0] got_peak [BARS];
  logic       got_last [BARS];
  int         nbeats;
  int         col_cycles;

  logic [3:0] exp_bar3  [7];
  logic [3:0] exp_peak3 [7];
  logic [3:0] rdy_pat;

  spectrum_bar_driver #(
    .SAMPLES(SAMPLES), .MAG_W(MAG_W), .BARS(BARS), .LEVEL_W(LEVEL_W),
    .SHIFT(8), .DECAY(1), .HOLD_FRAMES(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .magnitudes (mags),
    .frame_done (frame_done),
    .bar_ready  (bar_ready),
    .bar_valid  (bar_valid),
    .bar_index  (bar_index),
    .bar_level  (bar_level),
    .peak_level (peak_level),
    .bar_last   (bar_last),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mags();
    for (int i = 0; i < SAMPLES; i++) mags[i] = '0;
  endtask

  task automatic do_reset();
    frame_done = 1'b0;
    bar_ready  = 1'b0;
    clear_mags();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Raise frame_done for one capture edge, then drop it.
  task automatic start_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bar_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(bar_valid), 1);
  endtask

  // Collect one frame of beats; bp=1 drives ready with the 1,0,0,1 pattern
  // and checks that a stalled beat keeps its data.
  task automatic collect(input bit bp, input string tag);
    int  cyc = 0;
    bit  stalled = 1'b0;
    logic [2:0] h_idx = '0;
    logic [3:0] h_lvl = '0;
    logic [3:0] h_pk  = '0;
    nbeats = 0;
    while (nbeats < BARS && cyc < 300) begin
      bar_ready = bp ? rdy_pat[cyc % 4] : 1'b1;
      if (stalled) begin
        check({tag, "_hold_valid"}, 32'(bar_valid), 1);
        check({tag, "_hold_idx"},   32'(bar_index), 32'(h_idx));
        check({tag, "_hold_lvl"},   32'(bar_level), 32'(h_lvl));
        check({tag, "_hold_pk"},    32'(peak_level), 32'(h_pk));
      end
      if (bar_valid) begin
        if (bar_ready) begin
          got_idx[nbeats]  = bar_index;
          got_bar[nbeats]  = bar_level;
          got_peak[nbeats] = peak_level;
          got_last[nbeats] = bar_last;
          $display("beat %s idx=%0d level=%0d peak=%0d last=%0d",
                   tag, bar_index, bar_level, peak_level, bar_last);
          nbeats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_idx = bar_index;
          h_lvl = bar_level;
          h_pk  = peak_level;
        end
      end
      tick();
      cyc++;
    end
    col_cycles = cyc;
    bar_ready  = 1'b0;
    check({tag, "_beats"}, 32'(nbeats), BARS);
  endtask

  initial begin
    rdy_pat = 4'b1001;
    exp_bar3[0] = 4'd10; exp_bar3[1] = 4'd9; exp_bar3[2] = 4'd8; exp_bar3[3] = 4'd7;
    exp_bar3[4] = 4'd6;  exp_bar3[5] = 4'd5; exp_bar3[6] = 4'd4;
    exp_peak3[0] = 4'd10; exp_peak3[1] = 4'd10; exp_peak3[2] = 4'd10; exp_peak3[3] = 4'd10;
    exp_peak3[4] = 4'd10; exp_peak3[5] = 4'd9;  exp_peak3[6] = 4'd8;
    clear_mags();

    // Reset state while held in reset
    tick();
    check("rst_valid", 32'(bar_valid), 0);
    check("rst_index", 32'(bar_index), 0);
    check("rst_level", 32'(bar_level), 0);
    check("rst_peak",  32'(peak_level), 0);
    check("rst_last",  32'(bar_last), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_drop",  32'(drop_count), 0);
    reset_n = 1'b1;
    tick();

    // Quantise and first-beat latency
    do_reset();
    mags[0] = 18'h00500;
    mags[1] = 18'h3FFFF;
    start_frame();
    check("q_busy", 32'(busy), 1);
    repeat (8) tick();
    check("q_valid_early", 32'(bar_valid), 0);
    tick();
    check("q_valid_rise", 32'(bar_valid), 1);
    check("q_first_idx",  32'(bar_index), 0);
    collect(1'b0, "quant");
    check("q_consecutive", 32'(col_cycles), BARS);
    for (int b = 0; b < BARS; b++) begin
      check("q_idx",  32'(got_idx[b]), 32'(b));
      check("q_bar",  32'(got_bar[b]),  (b == 0) ? 5 : (b == 1) ? 15 : 0);
      check("q_peak", 32'(got_peak[b]), (b == 0) ? 5 : (b == 1) ? 15 : 0);
    end
    check("q_valid_after", 32'(bar_valid), 0);
    check("q_busy_after",  32'(busy), 0);

    // Decay and peak hold over 7 frames
    do_reset();
    for (int f = 0; f < 7; f++) begin
      mags[0] = (f == 0) ? 18'h00A00 : 18'h00000;
      start_frame();
      collect(1'b0, "decay");
      check("d_bar0",  32'(got_bar[0]),  32'(exp_bar3[f]));
      check("d_peak0", 32'(got_peak[0]), 32'(exp_peak3[f]));
    end

    // Backpressure with ready pattern 1,0,0,1
    do_reset();
    for (int i = 0; i < BARS; i++) mags[i] = MAG_W'((i + 1) << 8);
    start_frame();
    collect(1'b1, "bp");
    for (int b = 0; b < BARS; b++) begin
      check("bp_idx",  32'(got_idx[b]), 32'(b));
      check("bp_bar",  32'(got_bar[b]), 32'(b + 1));
      check("bp_last", 32'(got_last[b]), 32'(b == BARS - 1));
    end
    bar_ready = 1'b1;
    repeat (3) tick();
    check("bp_no_extra", 32'(bar_valid), 0);
    bar_ready = 1'b0;

    // Overrun during UPDATE and during SEND
    do_reset();
    start_frame();
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    check("ov_drop_update", 32'(drop_count), 1);
    wait_valid("ov_wait");
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    check("ov_drop_send", 32'(drop_count), 2);
    check("ov_still_idx0", 32'(bar_index), 0);
    collect(1'b0, "ov");
    check("ov_idle_busy",  32'(busy), 0);
    check("ov_idle_valid", 32'(bar_valid), 0);

    // Drop counter saturation
    start_frame();
    for (int i = 0; i < 300; i++) begin
      tick();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      if (i == 99) check("sat_drop_102", 32'(drop_count), 102);
    end
    check("sat_drop_255", 32'(drop_count), 255);
    collect(1'b0, "sat");

    // Edge on the final handshake is dropped; edge right after is accepted
    do_reset();
    start_frame();
    wait_valid("fh_wait_a");
    bar_ready = 1'b1;
    repeat (7) tick();
    check("fh_idx7_a",  32'(bar_index), 7);
    check("fh_last_a",  32'(bar_last), 1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    bar_ready  = 1'b0;
    check("fh_drop_final", 32'(drop_count), 1);
    check("fh_idle_busy",  32'(busy), 0);
    check("fh_idle_valid", 32'(bar_valid), 0);
    tick();
    start_frame();
    wait_valid("fh_wait_b");
    bar_ready = 1'b1;
    repeat (7) tick();
    check("fh_idx7_b", 32'(bar_index), 7);
    tick();
    bar_ready = 1'b0;
    check("fh_back_idle", 32'(busy), 0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("fh_accept_busy", 32'(busy), 1);
    check("fh_accept_drop", 32'(drop_count), 1);
    collect(1'b0, "fh");

    // Snapshot immunity and a long frame_done level
    do_reset();
    mags[0] = 18'h00300;
    mags[2] = 18'h00700;
    frame_done = 1'b1;
    tick();
    mags[0] = 18'h3FFFF;
    mags[1] = 18'h3FFFF;
    mags[2] = 18'h00000;
    collect(1'b0, "snap");
    check("snap_bar0", 32'(got_bar[0]), 3);
    check("snap_bar1", 32'(got_bar[1]), 0);
    check("snap_bar2", 32'(got_bar[2]), 7);
    repeat (50 - 1 - col_cycles) tick();
    check("snap_one_frame_busy",  32'(busy), 0);
    check("snap_one_frame_valid", 32'(bar_valid), 0);
    check("snap_no_drop",         32'(drop_count), 0);
    frame_done = 1'b0;
    tick();

    // Asynchronous reset in the middle of SEND
    do_reset();
    mags[0] = 18'h00F00;
    mags[3] = 18'h00C00;
    start_frame();
    wait_valid("ar_wait");
    bar_ready = 1'b1;
    repeat (3) tick();
    bar_ready = 1'b0;
    check("ar_idx3",   32'(bar_index), 3);
    check("ar_level3", 32'(bar_level), 12);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", 32'(bar_valid), 0);
    check("ar_index", 32'(bar_index), 0);
    check("ar_level", 32'(bar_level), 0);
    check("ar_peak",  32'(peak_level), 0);
    check("ar_busy",  32'(busy), 0);
    tick();
    tick();
    reset_n = 1'b1;
    clear_mags();
    repeat (12) tick();
    check("ar_no_more_beats", 32'(bar_valid), 0);
    start_frame();
    collect(1'b0, "ar_next");
    for (int b = 0; b < BARS; b++) begin
      check("ar_next_bar",  32'(got_bar[b]), 0);
      check("ar_next_peak", 32'(got_peak[b]), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
